// File: rtl/seg14_pkg.sv
// seg14_pkg: shared constants for the 12-digit 14-segment display link.
//   - DIGITS_DEFAULT : number of multiplexed digit positions.
//   - GLYPH_*        : 14-bit segment patterns, bit 13 = segment a.
//                      Bit order (MSB..LSB): a b c d e f g1 g2 h i j k l m.
//                      h/i/j are the upper-left diagonal, upper vertical and
//                      upper-right diagonal. k/l/m are the lower-right
//                      diagonal, lower vertical and lower-left diagonal.
//   - CH_*           : 7-bit ASCII codes produced by the decoder.
//   - fsm_state_e    : frame FSM states of the scan decoder.
// The driver side uses the same glyph constants, so both ends agree.
package seg14_pkg;

    localparam int DIGITS_DEFAULT = 12;

    typedef enum logic [0:0] {
        SYNC    = 1'b0,
        CAPTURE = 1'b1
    } fsm_state_e;

    localparam logic [13:0] GLYPH_SPACE = 14'b00000000000000;
    localparam logic [13:0] GLYPH_A = 14'b11101111000000, GLYPH_B = 14'b11110001010010;
    localparam logic [13:0] GLYPH_C = 14'b10011100000000, GLYPH_D = 14'b11110000010010;
    localparam logic [13:0] GLYPH_E = 14'b10011110000000, GLYPH_F = 14'b10001110000000;
    localparam logic [13:0] GLYPH_G = 14'b10111101000000, GLYPH_H = 14'b01101111000000;
    localparam logic [13:0] GLYPH_I = 14'b10010000010010, GLYPH_J = 14'b01111000000000;
    localparam logic [13:0] GLYPH_K = 14'b00001110001100, GLYPH_L = 14'b00011100000000;
    localparam logic [13:0] GLYPH_M = 14'b01101100101000, GLYPH_N = 14'b01101100100100;
    localparam logic [13:0] GLYPH_O = 14'b11111100000000, GLYPH_P = 14'b11001111000000;
    localparam logic [13:0] GLYPH_Q = 14'b11111100000100, GLYPH_R = 14'b11001111000100;
    localparam logic [13:0] GLYPH_S = 14'b10110111000000, GLYPH_T = 14'b10000000010010;
    localparam logic [13:0] GLYPH_U = 14'b01111100000000, GLYPH_V = 14'b00001100001001;
    localparam logic [13:0] GLYPH_W = 14'b01101100000101, GLYPH_X = 14'b00000000101101;
    localparam logic [13:0] GLYPH_Y = 14'b00000000101010, GLYPH_Z = 14'b10010000001001;
    localparam logic [13:0] GLYPH_0 = 14'b11111100001001, GLYPH_1 = 14'b01100000001000;
    localparam logic [13:0] GLYPH_2 = 14'b11011011000000, GLYPH_3 = 14'b11110001000000;
    localparam logic [13:0] GLYPH_4 = 14'b01100111000000, GLYPH_5 = GLYPH_S;
    localparam logic [13:0] GLYPH_6 = 14'b10111111000000, GLYPH_7 = 14'b10000000001010;
    localparam logic [13:0] GLYPH_8 = 14'b11111111000000, GLYPH_9 = 14'b11110111000000;

    localparam logic [6:0] CH_NUL = 7'h00, CH_SPACE = 7'h20, CH_UNKNOWN = 7'h3F;
    localparam logic [6:0] CH_A = 7'h41, CH_B = 7'h42, CH_C = 7'h43, CH_D = 7'h44, CH_E = 7'h45;
    localparam logic [6:0] CH_F = 7'h46, CH_G = 7'h47, CH_H = 7'h48, CH_I = 7'h49, CH_J = 7'h4A;
    localparam logic [6:0] CH_K = 7'h4B, CH_L = 7'h4C, CH_M = 7'h4D, CH_N = 7'h4E, CH_O = 7'h4F;
    localparam logic [6:0] CH_P = 7'h50, CH_Q = 7'h51, CH_R = 7'h52, CH_S = 7'h53, CH_T = 7'h54;
    localparam logic [6:0] CH_U = 7'h55, CH_V = 7'h56, CH_W = 7'h57, CH_X = 7'h58, CH_Y = 7'h59;
    localparam logic [6:0] CH_Z = 7'h5A;
    localparam logic [6:0] CH_0 = 7'h30, CH_1 = 7'h31, CH_2 = 7'h32, CH_3 = 7'h33, CH_4 = 7'h34;
    localparam logic [6:0] CH_5 = 7'h35, CH_6 = 7'h36, CH_7 = 7'h37, CH_8 = 7'h38, CH_9 = 7'h39;

endpackage

// File: rtl/seg14_scan_decoder_if.sv
// seg14_scan_decoder_if: bundle between the display-scan source / debug host
// (master) and the scan decoder (slave).
//   sel_in, segm_in : one-hot digit select and segment pattern, sampled every clock
//   err_clr         : single-cycle pulse clearing the sticky error flags
//   rd_addr/rd_data : combinational readout of the last committed frame
//   frame_*, err_*  : frame status and sticky error flags
//   dbg_state       : current frame FSM state, for observation only
// Transfer semantics: there is no valid/ready pair. Every clock edge is one
// transfer of (sel_in, segm_in); sel_in == 0 marks an idle beat, and the
// decoder never applies backpressure, so the source may change them each cycle.
interface seg14_scan_decoder_if
    import seg14_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT,
    parameter int SEGW   = 14,
    parameter int FCW    = 8
);
    logic [DIGITS-1:0] sel_in;
    logic [SEGW-1:0]   segm_in;
    logic              err_clr;
    logic [3:0]        rd_addr;
    logic [6:0]        rd_data;
    logic              frame_done;
    logic              frame_valid;
    logic [FCW-1:0]    frame_count;
    logic              err_sel;
    logic              err_seq;
    fsm_state_e        dbg_state;

    modport master (
        output sel_in, segm_in, err_clr, rd_addr,
        input  rd_data, frame_done, frame_valid, frame_count, err_sel, err_seq, dbg_state
    );

    modport slave (
        input  sel_in, segm_in, err_clr, rd_addr,
        output rd_data, frame_done, frame_valid, frame_count, err_sel, err_seq, dbg_state
    );
endinterface

// File: rtl/seg14_glyph_lut.sv
// seg14_glyph_lut: combinational 14-segment pattern to 7-bit ASCII decoder.
//   segm  : segment pattern, bit 13 = segment a
//   ascii : decoded character; unlisted patterns give '?'
// '5' shares its pattern with 'S'; the letter is reported, so no separate
// entry exists for the digit.
module seg14_glyph_lut
    import seg14_pkg::*;
#(
    parameter int SEGW = 14
) (
    input  logic [SEGW-1:0] segm,
    output logic [6:0]      ascii
);
    always_comb begin
        ascii = CH_UNKNOWN;
        case (segm)
            GLYPH_SPACE: ascii = CH_SPACE;
            GLYPH_A: ascii = CH_A;  GLYPH_B: ascii = CH_B;  GLYPH_C: ascii = CH_C;
            GLYPH_D: ascii = CH_D;  GLYPH_E: ascii = CH_E;  GLYPH_F: ascii = CH_F;
            GLYPH_G: ascii = CH_G;  GLYPH_H: ascii = CH_H;  GLYPH_I: ascii = CH_I;
            GLYPH_J: ascii = CH_J;  GLYPH_K: ascii = CH_K;  GLYPH_L: ascii = CH_L;
            GLYPH_M: ascii = CH_M;  GLYPH_N: ascii = CH_N;  GLYPH_O: ascii = CH_O;
            GLYPH_P: ascii = CH_P;  GLYPH_Q: ascii = CH_Q;  GLYPH_R: ascii = CH_R;
            GLYPH_S: ascii = CH_S;  GLYPH_T: ascii = CH_T;  GLYPH_U: ascii = CH_U;
            GLYPH_V: ascii = CH_V;  GLYPH_W: ascii = CH_W;  GLYPH_X: ascii = CH_X;
            GLYPH_Y: ascii = CH_Y;  GLYPH_Z: ascii = CH_Z;
            GLYPH_0: ascii = CH_0;  GLYPH_1: ascii = CH_1;  GLYPH_2: ascii = CH_2;
            GLYPH_3: ascii = CH_3;  GLYPH_4: ascii = CH_4;  GLYPH_6: ascii = CH_6;
            GLYPH_7: ascii = CH_7;  GLYPH_8: ascii = CH_8;  GLYPH_9: ascii = CH_9;
            default: ascii = CH_UNKNOWN;
        endcase
    end
endmodule

// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder: rebuilds the text shown on a 12-digit multiplexed
// 14-segment display by sniffing its digit-select and segment buses.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seg14_scan_decoder_if.slave (sample inputs, readout, status)
// Pipeline: stage 1 registers sel/segm; stage 2 classifies the select and
// decodes the glyph into registers; the frame FSM acts on stage 2 on the
// following edge. A digit-11 sample captured at edge N commits at edge N+2.
module seg14_scan_decoder
    import seg14_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT,
    parameter int SEGW   = 14,
    parameter int FCW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg14_scan_decoder_if.slave  bus
);
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    // stage 1
    logic [DIGITS-1:0] s1_sel_q, s1_sel_d;
    logic [SEGW-1:0]   s1_segm_q, s1_segm_d;
    logic              s1_valid_q, s1_valid_d;
    // stage 2: only non-idle beats are marked valid
    logic              s2_valid_q, s2_valid_d;
    logic              s2_multi_q, s2_multi_d;
    logic [3:0]        s2_idx_q, s2_idx_d;
    logic [6:0]        s2_char_q, s2_char_d;
    // frame state
    fsm_state_e        state_q, state_d;
    logic [3:0]        exp_q, exp_d;
    logic [6:0]        work_q [DIGITS];
    logic [6:0]        work_d [DIGITS];
    logic [6:0]        shadow_q [DIGITS];
    logic [6:0]        shadow_d [DIGITS];
    logic              frame_done_q, frame_done_d;
    logic              frame_valid_q, frame_valid_d;
    logic [FCW-1:0]    frame_count_q, frame_count_d;
    logic              err_sel_q, err_sel_d;
    logic              err_seq_q, err_seq_d;

    logic [3:0]        sel_idx;
    logic [6:0]        s1_char;
    logic [6:0]        rd_data;

    seg14_glyph_lut #(.SEGW(SEGW)) u_glyph_lut (
        .segm  (s1_segm_q),
        .ascii (s1_char)
    );

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (s1_sel_q[k]) sel_idx = 4'(k);
        end
    end

    always_comb begin
        s1_sel_d   = bus.sel_in;
        s1_segm_d  = bus.segm_in;
        s1_valid_d = 1'b1;
        s2_valid_d = s1_valid_q && (s1_sel_q != '0);
        // x & (x-1) clears the lowest set bit; non-zero means multi-hot
        s2_multi_d = (s1_sel_q & (s1_sel_q - 1'b1)) != '0;
        s2_idx_d   = sel_idx;
        s2_char_d  = s1_char;
    end

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        work_d        = work_q;
        shadow_d      = shadow_q;
        frame_done_d  = 1'b0;
        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;
        // clear first so a same-cycle error event below re-sets the flag
        err_sel_d     = err_sel_q & ~bus.err_clr;
        err_seq_d     = err_seq_q & ~bus.err_clr;
        if (s2_valid_q) begin
            if (s2_multi_q) begin
                err_sel_d = 1'b1;
            end else if (state_q == SYNC) begin
                if (s2_idx_q == 4'd0) begin
                    work_d[0] = s2_char_q;
                    exp_d     = 4'd1;
                    state_d   = CAPTURE;
                end
            end else if (s2_idx_q == exp_q - 4'd1) begin
                // dwell on the digit already written: last value wins
                work_d[s2_idx_q] = s2_char_q;
            end else if (s2_idx_q == exp_q) begin
                work_d[s2_idx_q] = s2_char_q;
                if (exp_q == LAST_IDX) begin
                    shadow_d      = work_d;
                    frame_done_d  = 1'b1;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + FCW'(1);
                    exp_d         = 4'd0;
                    state_d       = SYNC;
                end else begin
                    exp_d = exp_q + 4'd1;
                end
            end else begin
                err_seq_d = 1'b1;
                if (s2_idx_q == 4'd0) begin
                    work_d[0] = s2_char_q;
                    exp_d     = 4'd1;
                    state_d   = CAPTURE;
                end else begin
                    exp_d   = 4'd0;
                    state_d = SYNC;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_sel_q      <= '0;
            s1_segm_q     <= '0;
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_multi_q    <= 1'b0;
            s2_idx_q      <= '0;
            s2_char_q     <= CH_SPACE;
            state_q       <= SYNC;
            exp_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            err_sel_q     <= 1'b0;
            err_seq_q     <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                work_q[i]   <= CH_SPACE;
                shadow_q[i] <= CH_SPACE;
            end
        end else begin
            s1_sel_q      <= s1_sel_d;
            s1_segm_q     <= s1_segm_d;
            s1_valid_q    <= s1_valid_d;
            s2_valid_q    <= s2_valid_d;
            s2_multi_q    <= s2_multi_d;
            s2_idx_q      <= s2_idx_d;
            s2_char_q     <= s2_char_d;
            state_q       <= state_d;
            exp_q         <= exp_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            err_sel_q     <= err_sel_d;
            err_seq_q     <= err_seq_d;
            for (int i = 0; i < DIGITS; i++) begin
                work_q[i]   <= work_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    always_comb begin
        rd_data = CH_NUL;
        if (int'(bus.rd_addr) < DIGITS) rd_data = shadow_q[bus.rd_addr];
    end

    assign bus.rd_data     = rd_data;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_sel     = err_sel_q;
    assign bus.err_seq     = err_seq_q;
    assign bus.dbg_state   = state_q;
endmodule
